// File: rtl/doc_geom_pkg.sv
// Shared geometry, character codes and state types for the UART document loader.
package doc_geom_pkg;

  localparam int unsigned ROWS      = 15;
  localparam int unsigned COLS      = 20;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned COL_W     = 5;
  localparam int unsigned DOC_AW    = 9;
  localparam int unsigned CNT_W     = 9;
  localparam int unsigned MAX_CHARS = ROWS * COLS;

  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic {
    W_IDLE,
    W_REQ
  } wr_state_t;

  // Document address is the cursor itself: {row, col}
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } cursor_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

  // Previous cell in row-major order; caller guarantees c is not (0,0)
  function automatic cursor_t cur_prev(input cursor_t c);
    cursor_t p;
    p = c;
    if (c.col == '0) begin
      p.row = c.row - 1'b1;
      p.col = COL_W'(COLS - 1);
    end else begin
      p.col = c.col - 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, 16x oversample tick and framing FSM.
module uart_rx_core
  import doc_geom_pkg::*;
#(
  parameter int unsigned OVS_DIV = 651
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_byte_valid,
  output logic       o_frame_err_pulse
);

  localparam int unsigned OVS_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [OVS_W-1:0] r_ovs_cnt;
  logic             w_tick;

  rx_state_t  r_state,         w_state_nxt;
  logic [3:0] r_tick_cnt,      w_tick_cnt_nxt;
  logic [2:0] r_bit_idx,       w_bit_idx_nxt;
  logic [7:0] r_shift,         w_shift_nxt;
  logic       r_byte_valid,    w_byte_valid_nxt;
  logic       r_frame_err_pls, w_frame_err_pls_nxt;

  assign w_tick            = (r_ovs_cnt == OVS_W'(OVS_DIV - 1));
  assign o_data            = r_shift;
  assign o_byte_valid      = r_byte_valid;
  assign o_frame_err_pulse = r_frame_err_pls;

  // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Free-running oversample divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovs_cnt <= '0;
    end else if (w_tick) begin
      r_ovs_cnt <= '0;
    end else begin
      r_ovs_cnt <= r_ovs_cnt + 1'b1;
    end
  end

  // RX state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= RX_IDLE;
      r_tick_cnt      <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_byte_valid    <= 1'b0;
      r_frame_err_pls <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_tick_cnt      <= w_tick_cnt_nxt;
      r_bit_idx       <= w_bit_idx_nxt;
      r_shift         <= w_shift_nxt;
      r_byte_valid    <= w_byte_valid_nxt;
      r_frame_err_pls <= w_frame_err_pls_nxt;
    end
  end

  // Framing: start mid-bit check, 8 data samples LSB first, stop check
  always_comb begin
    w_state_nxt         = r_state;
    w_tick_cnt_nxt      = r_tick_cnt;
    w_bit_idx_nxt       = r_bit_idx;
    w_shift_nxt         = r_shift;
    w_byte_valid_nxt    = 1'b0;
    w_frame_err_pls_nxt = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_state_nxt    = RX_START;
          w_tick_cnt_nxt = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_tick_cnt == 4'd7) begin
            if (r_rx_sync) begin
              w_state_nxt = RX_IDLE;
            end else begin
              w_state_nxt    = RX_DATA;
              w_tick_cnt_nxt = '0;
              w_bit_idx_nxt  = '0;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_tick_cnt == 4'd15) begin
            w_shift_nxt    = {r_rx_sync, r_shift[7:1]};
            w_tick_cnt_nxt = '0;
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = RX_STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + 1'b1;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_tick_cnt == 4'd15) begin
            if (r_rx_sync) begin
              w_byte_valid_nxt = 1'b1;
              w_state_nxt      = RX_IDLE;
            end else begin
              w_frame_err_pls_nxt = 1'b1;
              w_state_nxt         = RX_BREAK;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      RX_BREAK: begin
        if (r_rx_sync) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_doc_loader.sv
// Places received UART characters into the document RAM through a req/ack write port.
module uart_doc_loader
  import doc_geom_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RsRx,
  input  logic              enable,
  input  logic              clear_pos,
  output logic [DOC_AW-1:0] doc_a,
  output logic [7:0]        doc_d,
  output logic              doc_req,
  input  logic              doc_ack,
  output logic              full,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  char_count
);

  localparam int unsigned OVS_DIV = CLK_HZ / (BAUD * 16);

  logic [7:0] w_rx_data;
  logic       w_byte_valid;
  logic       w_frame_err_pulse;

  wr_state_t        r_state,     w_state_nxt;
  cursor_t          r_cur,       w_cur_nxt;
  cursor_t          r_doc_a,     w_doc_a_nxt;
  logic [7:0]       r_doc_d,     w_doc_d_nxt;
  logic             r_doc_req,   w_doc_req_nxt;
  logic             r_is_bs,     w_is_bs_nxt;
  logic             r_full,      w_full_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             r_overrun,   w_overrun_nxt;
  logic [CNT_W-1:0] r_count,     w_count_nxt;

  uart_rx_core #(
    .OVS_DIV (OVS_DIV)
  ) u_rx (
    .clk               (clk),
    .rst               (rst),
    .i_rx              (RsRx),
    .o_data            (w_rx_data),
    .o_byte_valid      (w_byte_valid),
    .o_frame_err_pulse (w_frame_err_pulse)
  );

  assign doc_a      = r_doc_a;
  assign doc_d      = r_doc_d;
  assign doc_req    = r_doc_req;
  assign full       = r_full;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign char_count = r_count;

  // Writer state, cursor and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= W_IDLE;
      r_cur       <= '0;
      r_doc_a     <= '0;
      r_doc_d     <= '0;
      r_doc_req   <= 1'b0;
      r_is_bs     <= 1'b0;
      r_full      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_doc_a     <= w_doc_a_nxt;
      r_doc_d     <= w_doc_d_nxt;
      r_doc_req   <= w_doc_req_nxt;
      r_is_bs     <= w_is_bs_nxt;
      r_full      <= w_full_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
      r_count     <= w_count_nxt;
    end
  end

  // Byte decode, write handshake and cursor bookkeeping.
  // Backspace stays accepted while full so the last cells can still be erased;
  // the cursor is parked on the last cell once full.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur;
    w_doc_a_nxt     = r_doc_a;
    w_doc_d_nxt     = r_doc_d;
    w_doc_req_nxt   = r_doc_req;
    w_is_bs_nxt     = r_is_bs;
    w_full_nxt      = r_full;
    w_frame_err_nxt = r_frame_err;
    w_overrun_nxt   = r_overrun;
    w_count_nxt     = r_count;

    unique case (r_state)
      W_IDLE: begin
        if (w_byte_valid && enable) begin
          if (is_printable(w_rx_data)) begin
            if (!r_full) begin
              w_state_nxt   = W_REQ;
              w_doc_req_nxt = 1'b1;
              w_doc_a_nxt   = r_cur;
              w_doc_d_nxt   = w_rx_data;
              w_is_bs_nxt   = 1'b0;
            end
          end else begin
            case (w_rx_data)
              ASCII_NL: begin
                if (!r_full) begin
                  if (r_cur.row == ROW_W'(ROWS - 1)) begin
                    w_full_nxt    = 1'b1;
                    w_cur_nxt.col = COL_W'(COLS - 1);
                  end else begin
                    w_cur_nxt.row = r_cur.row + 1'b1;
                    w_cur_nxt.col = '0;
                  end
                end
              end
              ASCII_BS: begin
                if (r_cur != '0) begin
                  w_state_nxt   = W_REQ;
                  w_doc_req_nxt = 1'b1;
                  w_doc_a_nxt   = cur_prev(r_cur);
                  w_doc_d_nxt   = ASCII_SPACE;
                  w_is_bs_nxt   = 1'b1;
                end
              end
              ASCII_CR: begin
              end
              default: begin
              end
            endcase
          end
        end
      end
      W_REQ: begin
        if (w_byte_valid) begin
          w_overrun_nxt = 1'b1;
        end
        if (doc_ack) begin
          w_state_nxt   = W_IDLE;
          w_doc_req_nxt = 1'b0;
          w_cur_nxt     = r_doc_a;
          if (r_is_bs) begin
            if (r_count != '0) begin
              w_count_nxt = r_count - 1'b1;
            end
          end else begin
            if (r_doc_a.col == COL_W'(COLS - 1)) begin
              if (r_doc_a.row == ROW_W'(ROWS - 1)) begin
                w_full_nxt = 1'b1;
              end else begin
                w_cur_nxt.row = r_doc_a.row + 1'b1;
                w_cur_nxt.col = '0;
              end
            end else begin
              w_cur_nxt.col = r_doc_a.col + 1'b1;
            end
            if (r_count != CNT_W'(MAX_CHARS)) begin
              w_count_nxt = r_count + 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt   = W_IDLE;
        w_doc_req_nxt = 1'b0;
      end
    endcase

    if (w_frame_err_pulse) begin
      w_frame_err_nxt = 1'b1;
    end

    // Cursor reset aborts any pending write and drops a same-cycle byte
    if (clear_pos) begin
      w_state_nxt     = W_IDLE;
      w_doc_req_nxt   = 1'b0;
      w_cur_nxt       = '0;
      w_full_nxt      = 1'b0;
      w_frame_err_nxt = 1'b0;
      w_overrun_nxt   = 1'b0;
      w_count_nxt     = '0;
    end
  end

endmodule

// File: tb/tb_uart_doc_loader.sv
// Self-checking bench for uart_doc_loader (runs with a 1-clock oversample tick).
module tb_uart_doc_loader;

  localparam int unsigned CLK_HZ   = 160_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int unsigned BIT_CLKS = 16;
  localparam int unsigned GAP_CLKS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       RsRx;
  logic       enable;
  logic       clear_pos;
  logic [8:0] doc_a;
  logic [7:0] doc_d;
  logic       doc_req;
  logic       doc_ack;
  logic       full;
  logic       frame_err;
  logic       overrun;
  logic [8:0] char_count;

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] b;
    bit         wr;
    logic [8:0] a;
    logic [7:0] d;
    logic [8:0] cnt;
  } vec_t;

  wr_t obs_q[$];
  wr_t exp_q[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state: linear cell index, full flag, character count
  int m_pos;
  bit m_full;
  int m_count;

  always #5 clk = ~clk;

  uart_doc_loader #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RsRx       (RsRx),
    .enable     (enable),
    .clear_pos  (clear_pos),
    .doc_a      (doc_a),
    .doc_d      (doc_d),
    .doc_req    (doc_req),
    .doc_ack    (doc_ack),
    .full       (full),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .char_count (char_count)
  );

  // Record every completed document write
  always @(negedge clk) begin
    if (!rst && doc_req && doc_ack) obs_q.push_back(wr_t'({doc_a, doc_d}));
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pos_addr(input int p);
    return 9'((p / 20) * 32 + (p % 20));
  endfunction

  function automatic void model_clear();
    m_pos   = 0;
    m_full  = 1'b0;
    m_count = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit en);
    if (!en) return;
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (!m_full) begin
        exp_q.push_back(wr_t'({pos_addr(m_pos), b}));
        m_count++;
        if (m_pos == 299) m_full = 1'b1;
        else m_pos++;
      end
    end else if (b == 8'h0A) begin
      if (!m_full) begin
        if (m_pos / 20 == 14) begin
          m_full = 1'b1;
          m_pos  = 299;
        end else begin
          m_pos = (m_pos / 20 + 1) * 20;
        end
      end
    end else if (b == 8'h08) begin
      if (m_pos != 0) begin
        m_pos--;
        exp_q.push_back(wr_t'({pos_addr(m_pos), 8'h20}));
        if (m_count > 0) m_count--;
      end
    end
  endfunction

  task automatic compare_queues(input string name);
    int n;
    check({name, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        check({name, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
      end else begin
        n_vec++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    RsRx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    RsRx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    RsRx = 1'b1;
    repeat (GAP_CLKS) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_pos = 1'b1;
    @(negedge clk);
    clear_pos = 1'b0;
  endtask

  vec_t tbl[11];

  initial begin
    int         n0;
    logic [7:0] b;
    bit         en;
    int         r;

    tbl[0]  = '{8'h48, 1'b1, 9'h000, 8'h48, 9'd1};
    tbl[1]  = '{8'h49, 1'b1, 9'h001, 8'h49, 9'd2};
    tbl[2]  = '{8'h0D, 1'b0, 9'h000, 8'h00, 9'd2};
    tbl[3]  = '{8'h0A, 1'b0, 9'h000, 8'h00, 9'd2};
    tbl[4]  = '{8'h59, 1'b1, 9'h020, 8'h59, 9'd3};
    tbl[5]  = '{8'h08, 1'b1, 9'h020, 8'h20, 9'd2};
    tbl[6]  = '{8'h08, 1'b1, 9'h013, 8'h20, 9'd1};
    tbl[7]  = '{8'h01, 1'b0, 9'h000, 8'h00, 9'd1};
    tbl[8]  = '{8'h7F, 1'b0, 9'h000, 8'h00, 9'd1};
    tbl[9]  = '{8'h7E, 1'b1, 9'h013, 8'h7E, 9'd2};
    tbl[10] = '{8'h20, 1'b1, 9'h020, 8'h20, 9'd3};

    rst       = 1'b1;
    RsRx      = 1'b1;
    enable    = 1'b1;
    clear_pos = 1'b0;
    doc_ack   = 1'b1;
    repeat (5) @(negedge clk);

    check("rst_doc_req",    32'(doc_req), 32'd0);
    check("rst_doc_a",      32'(doc_a), 32'd0);
    check("rst_doc_d",      32'(doc_d), 32'd0);
    check("rst_full",       32'(full), 32'd0);
    check("rst_frame_err",  32'(frame_err), 32'd0);
    check("rst_overrun",    32'(overrun), 32'd0);
    check("rst_char_count", 32'(char_count), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_doc_req", 32'(doc_req), 32'd0);

    // Table-driven single bytes from a freshly reset cursor
    for (int i = 0; i < 11; i++) begin
      n0 = obs_q.size();
      send_byte(tbl[i].b, 1'b1);
      check($sformatf("tbl%0d_nwr", i), 32'(obs_q.size() - n0), 32'(tbl[i].wr));
      if (tbl[i].wr && obs_q.size() > n0) begin
        check($sformatf("tbl%0d_addr", i), 32'(obs_q[n0].a), 32'(tbl[i].a));
        check($sformatf("tbl%0d_data", i), 32'(obs_q[n0].d), 32'(tbl[i].d));
      end
      check($sformatf("tbl%0d_count", i), 32'(char_count), 32'(tbl[i].cnt));
    end

    // 20 x 'A' then 'B' wraps to row 1
    pulse_clear();
    obs_q.delete();
    repeat (20) send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    check("wrap_nwrites", 32'(obs_q.size()), 32'd21);
    if (obs_q.size() == 21) begin
      check("wrap_a19_addr", 32'(obs_q[19].a), 32'h013);
      check("wrap_b_addr", 32'(obs_q[20].a), 32'h020);
      check("wrap_b_data", 32'(obs_q[20].d), 32'h42);
    end

    // "X\nY"
    pulse_clear();
    obs_q.delete();
    send_byte(8'h58, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h59, 1'b1);
    check("nl_nwrites", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("nl_y_addr", 32'(obs_q[1].a), 32'h020);
      check("nl_y_data", 32'(obs_q[1].d), 32'h59);
    end

    // Framing error, recovery, then clear
    pulse_clear();
    obs_q.delete();
    send_byte(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    check("ferr_nwrites", 32'(obs_q.size()), 32'd0);
    check("ferr_flag", 32'(frame_err), 32'd1);
    send_byte(8'h51, 1'b1);
    check("ferr_next_nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) check("ferr_next_write", 32'(obs_q[0]), 32'({9'h000, 8'h51}));
    pulse_clear();
    check("ferr_cleared", 32'(frame_err), 32'd0);
    check("ferr_count_cleared", 32'(char_count), 32'd0);

    // Overrun: ack held low across two more byte times
    doc_ack = 1'b0;
    obs_q.delete();
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    check("ovr_req_held", 32'(doc_req), 32'd1);
    check("ovr_addr_held", 32'(doc_a), 32'h000);
    check("ovr_data_held", 32'(doc_d), 32'h41);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_no_write_yet", 32'(obs_q.size()), 32'd0);
    doc_ack = 1'b1;
    repeat (6) @(negedge clk);
    check("ovr_nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) check("ovr_write", 32'(obs_q[0]), 32'({9'h000, 8'h41}));
    check("ovr_req_dropped", 32'(doc_req), 32'd0);
    check("ovr_count", 32'(char_count), 32'd1);
    pulse_clear();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // clear_pos aborts a pending write
    doc_ack = 1'b0;
    obs_q.delete();
    send_byte(8'h41, 1'b1);
    check("abort_req_before", 32'(doc_req), 32'd1);
    pulse_clear();
    check("abort_req_after", 32'(doc_req), 32'd0);
    doc_ack = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_write", 32'(obs_q.size()), 32'd0);
    send_byte(8'h4B, 1'b1);
    check("abort_next_nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) check("abort_next_write", 32'(obs_q[0]), 32'({9'h000, 8'h4B}));

    // Randomized mix of codes and enable levels against the model
    pulse_clear();
    model_clear();
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       b = 8'($urandom_range(32, 126));
      else if (r == 6) b = 8'h0A;
      else if (r == 7) b = 8'h08;
      else if (r == 8) b = 8'h0D;
      else             b = 8'($urandom_range(128, 255));
      en = ($urandom_range(0, 7) != 0);
      enable = en;
      send_byte(b, 1'b1);
      model_byte(b, en);
    end
    enable = 1'b1;
    compare_queues("rand");
    check("rand_count", 32'(char_count), 32'(m_count));
    check("rand_full", 32'(full), 32'(m_full));

    // Fill all 300 cells, then overflow and backspace
    pulse_clear();
    model_clear();
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom_range(32, 126));
      send_byte(b, 1'b1);
      model_byte(b, 1'b1);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(char_count), 32'd300);
    if (obs_q.size() > 0) check("fill_last_addr", 32'(obs_q[obs_q.size() - 1].a), 32'({4'd14, 5'd19}));
    n0 = obs_q.size();
    send_byte(8'h41, 1'b1);
    model_byte(8'h41, 1'b1);
    check("fill_301_dropped", 32'(obs_q.size() - n0), 32'd0);
    send_byte(8'h08, 1'b1);
    model_byte(8'h08, 1'b1);
    if (obs_q.size() > 0) check("fill_bs_write", 32'(obs_q[obs_q.size() - 1]), 32'({4'd14, 5'd18, 8'h20}));
    check("fill_bs_count", 32'(char_count), 32'd299);
    compare_queues("fill");

    // Reset in the middle of a data phase
    obs_q.delete();
    @(negedge clk);
    RsRx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    RsRx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    RsRx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst  = 1'b1;
    RsRx = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_count", 32'(char_count), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    send_byte(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("midrst_nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) check("midrst_write", 32'(obs_q[0]), 32'({9'h000, 8'h5A}));
    check("midrst_final_count", 32'(char_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
